// File: rtl/status_cond_unit.sv
// Architectural {N,Z,C,V} status register plus ARM condition-code check for the ID stage.
// Resolves the flag RAW hazard by EXE-flag forwarding (BYPASS=1) or a one-cycle ID stall (BYPASS=0).
module status_cond_unit #(
    parameter bit          BYPASS = 1'b1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       status_in,
    input  logic             s_update,
    input  logic             id_valid,
    input  logic [3:0]       cond,
    input  logic             flush,
    output logic [3:0]       status_out,
    output logic             cond_pass,
    output logic             stall,
    output logic [CNT_W-1:0] fail_count
);

    logic [3:0]       statusQ;
    logic [CNT_W-1:0] failCntQ, failCntD;
    logic [3:0]       flags;
    logic             stallInt;
    logic             issue;
    logic             truth;

    function automatic logic condTrue(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        n  = f[3];
        z  = f[2];
        cy = f[1];
        v  = f[0];
        case (c)
            4'b0000: condTrue = z;
            4'b0001: condTrue = ~z;
            4'b0010: condTrue = cy;
            4'b0011: condTrue = ~cy;
            4'b0100: condTrue = n;
            4'b0101: condTrue = ~n;
            4'b0110: condTrue = v;
            4'b0111: condTrue = ~v;
            4'b1000: condTrue = cy & ~z;
            4'b1001: condTrue = ~cy | z;
            4'b1010: condTrue = (n == v);
            4'b1011: condTrue = (n != v);
            4'b1100: condTrue = ~z & (n == v);
            4'b1101: condTrue = z | (n != v);
            4'b1110: condTrue = 1'b1;
            default: condTrue = 1'b0;
        endcase
    endfunction

    generate
        if (BYPASS) begin : gBypass
            // Forward the flags being committed this cycle so the ID check never waits.
            assign flags    = s_update ? status_in : statusQ;
            assign stallInt = 1'b0;
        end else begin : gStall
            typedef enum logic [0:0] {StCheck, StWait} stateE;
            stateE stateQ, stateD;
            logic  hazard;

            // AL never depends on the flags, so it cannot hazard.
            assign hazard = id_valid & s_update & (cond != 4'b1110);
            assign flags  = statusQ;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    stateQ <= StCheck;
                end else begin
                    stateQ <= stateD;
                end
            end

            // WAIT never stalls, so a second s_update while held cannot extend the stall.
            always_comb begin
                stateD   = StCheck;
                stallInt = 1'b0;
                unique case (stateQ)
                    StCheck: begin
                        stallInt = hazard & ~flush & ~rst;
                        if (stallInt) begin
                            stateD = StWait;
                        end
                    end
                    StWait:  stateD = StCheck;
                    default: stateD = StCheck;
                endcase
            end
        end
    endgenerate

    assign truth = condTrue(cond, flags);
    assign issue = id_valid & ~stallInt & ~flush;

    always_comb begin
        failCntD = failCntQ;
        if (issue && !truth && (failCntQ != {CNT_W{1'b1}})) begin
            failCntD = failCntQ + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            statusQ  <= 4'b0000;
            failCntQ <= '0;
        end else begin
            if (s_update) begin
                statusQ <= status_in;
            end
            failCntQ <= failCntD;
        end
    end

    assign status_out = statusQ;
    assign cond_pass  = issue & truth;
    assign stall      = stallInt;
    assign fail_count = failCntQ;

endmodule

// File: tb/tb_status_cond_unit.sv
// Scoreboard bench: dut0 is the stalling variant with a 4-bit counter, dut1 the bypass variant.
module tb_status_cond_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  si0, cd0, si1, cd1;
    logic        su0, iv0, fl0, su1, iv1, fl1;
    logic [3:0]  so0, so1;
    logic        st0, st1, p0, p1;
    logic [3:0]  fc0;
    logic [15:0] fc1;

    typedef struct {
        string       name;
        bit          dut;
        bit          cS;
        logic        eS;
        bit          cP;
        logic        eP;
        bit          cO;
        logic [3:0]  eO;
        bit          cC;
        logic [15:0] eC;
    } expT;

    expT expQ[$];
    expT mon;
    int  total = 0;
    int  bad   = 0;

    status_cond_unit #(.BYPASS(1'b0), .CNT_W(4)) dut0 (
        .clk(clk), .rst(rst), .status_in(si0), .s_update(su0), .id_valid(iv0), .cond(cd0),
        .flush(fl0), .status_out(so0), .cond_pass(p0), .stall(st0), .fail_count(fc0)
    );

    status_cond_unit #(.BYPASS(1'b1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .status_in(si1), .s_update(su1), .id_valid(iv1), .cond(cd1),
        .flush(fl1), .status_out(so1), .cond_pass(p1), .stall(st1), .fail_count(fc1)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input string field, input logic [15:0] act,
                       input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s.%s: got %0h expected %0h", name, field, act, exp);
        end
    endtask

    task automatic push(input string n, input bit d, input bit cS, input logic eS, input bit cP,
                        input logic eP, input bit cO, input logic [3:0] eO, input bit cC,
                        input logic [15:0] eC);
        expT e;
        e.name = n; e.dut = d;
        e.cS = cS; e.eS = eS; e.cP = cP; e.eP = eP;
        e.cO = cO; e.eO = eO; e.cC = cC; e.eC = eC;
        expQ.push_back(e);
    endtask

    task automatic d0(input logic su, input logic [3:0] si, input logic iv, input logic [3:0] cd,
                      input logic fl);
        su0 = su; si0 = si; iv0 = iv; cd0 = cd; fl0 = fl;
    endtask

    task automatic d1(input logic su, input logic [3:0] si, input logic iv, input logic [3:0] cd,
                      input logic fl);
        su1 = su; si1 = si; iv1 = iv; cd1 = cd; fl1 = fl;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs are sampled on the falling edge, away from state updates.
    always @(negedge clk) begin
        while (expQ.size() > 0) begin
            mon = expQ.pop_front();
            if (mon.cS) cmp(mon.name, "stall", 16'(mon.dut ? st1 : st0), 16'(mon.eS));
            if (mon.cP) cmp(mon.name, "pass", 16'(mon.dut ? p1 : p0), 16'(mon.eP));
            if (mon.cO) cmp(mon.name, "status", 16'(mon.dut ? so1 : so0), 16'(mon.eO));
            if (mon.cC) cmp(mon.name, "count", mon.dut ? fc1 : 16'(fc0), mon.eC);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        d0(0, 4'h0, 0, 4'h0, 0);
        d1(0, 4'h0, 0, 4'h0, 0);
        cyc(); cyc();
        push("rst0", 0, 1, 0, 1, 0, 1, 4'h0, 1, 0);
        push("rst1", 1, 1, 0, 1, 0, 1, 4'h0, 1, 0);
        cyc(); rst = 1'b0;

        // Build up a stall, then reset while the FSM sits in WAIT with the hazard still present.
        d0(1, 4'b0100, 0, 4'h0, 0);      push("commitA", 0, 1, 0, 1, 0, 1, 4'h0, 1, 0);
        cyc(); d0(1, 4'b0110, 1, 4'b0000, 0); push("hazB", 0, 1, 1, 1, 0, 1, 4'b0100, 1, 0);
        cyc();                                push("waitC", 0, 1, 0, 1, 1, 1, 4'b0110, 1, 0);
        @(negedge clk); #2 rst = 1'b1;
        push("rstWait", 0, 1, 0, 1, 0, 1, 4'h0, 1, 0);
        @(negedge clk); #1 rst = 1'b0;
        d0(0, 4'h0, 0, 4'h0, 0);

        cyc(); d0(1, 4'b0100, 0, 4'h0, 0);    push("commitD", 0, 1, 0, 1, 0, 1, 4'h0, 1, 0);
        cyc(); d0(0, 4'h0, 1, 4'b0000, 0);    push("eqPass", 0, 1, 0, 1, 1, 1, 4'b0100, 1, 0);
        cyc(); d0(0, 4'h0, 1, 4'b0001, 0);    push("neFail", 0, 1, 0, 1, 0, 1, 4'b0100, 1, 0);
        cyc(); d0(1, 4'b0000, 0, 4'h0, 0);    push("cnt1", 0, 1, 0, 1, 0, 1, 4'b0100, 1, 1);

        cyc(); d0(1, 4'b1000, 1, 4'b0100, 0); push("stallI", 0, 1, 1, 1, 0, 1, 4'b0000, 1, 1);
        cyc(); d0(0, 4'h0, 1, 4'b0100, 0);    push("waitJ", 0, 1, 0, 1, 1, 1, 4'b1000, 1, 1);
        cyc(); d0(1, 4'b0000, 1, 4'b1110, 0); push("alL", 0, 1, 0, 1, 1, 1, 4'b1000, 1, 1);
        cyc(); d0(0, 4'h0, 1, 4'b1111, 0);    push("nvM", 0, 1, 0, 1, 0, 1, 4'b0000, 1, 1);
        cyc(); d0(1, 4'b0001, 1, 4'b0110, 0); push("hazN", 0, 1, 1, 1, 0, 1, 4'b0000, 1, 2);
        cyc(); d0(1, 4'b0000, 1, 4'b0110, 0); push("waitN", 0, 1, 0, 1, 1, 1, 4'b0001, 1, 2);
        cyc(); d0(1, 4'b0100, 1, 4'b1111, 1); push("flushO", 0, 1, 0, 1, 0, 1, 4'b0000, 1, 2);
        cyc(); d0(0, 4'h0, 0, 4'h0, 0);       push("flushP", 0, 1, 0, 1, 0, 1, 4'b0100, 1, 2);

        for (int i = 0; i < 20; i++) begin
            cyc(); d0(0, 4'h0, 1, 4'b1111, 0);
            if (i == 12) push("sat14", 0, 0, 0, 0, 0, 0, 4'h0, 1, 14);
            if (i == 13) push("sat15", 0, 0, 0, 0, 0, 0, 4'h0, 1, 15);
        end
        cyc(); d0(0, 4'h0, 0, 4'h0, 0);       push("satEnd", 0, 1, 0, 1, 0, 0, 4'h0, 1, 15);

        cyc(); d1(1, 4'b1000, 1, 4'b0100, 0); push("byp1", 1, 1, 0, 1, 1, 1, 4'b0000, 1, 0);
        cyc(); d1(0, 4'h0, 1, 4'b0101, 0);    push("byp2", 1, 1, 0, 1, 0, 1, 4'b1000, 1, 0);
        cyc(); d1(1, 4'b0010, 1, 4'b1000, 0); push("byp3", 1, 1, 0, 1, 1, 1, 4'b1000, 1, 1);
        cyc(); d1(1, 4'b1001, 1, 4'b1010, 0); push("byp4", 1, 1, 0, 1, 1, 1, 4'b0010, 1, 1);
        cyc(); d1(0, 4'h0, 1, 4'b1101, 0);    push("byp5", 1, 1, 0, 1, 0, 1, 4'b1001, 1, 1);
        cyc(); d1(1, 4'b0000, 1, 4'b1111, 0); push("byp6", 1, 1, 0, 1, 0, 1, 4'b1001, 1, 2);
        cyc(); d1(0, 4'h0, 0, 4'h0, 0);       push("byp7", 1, 1, 0, 1, 0, 1, 4'b0000, 1, 3);
        push("satHold", 0, 0, 0, 0, 0, 0, 4'h0, 1, 15);

        @(negedge clk); #1;
        cmp("drain", "queue", 16'(expQ.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
